instruction_memory_banked: RTL and testbench
============================================

// Module: instruction_memory_banked
// PURPOSE
//  Parametrised, double-buffered successor to the wide-instruction store. Two banks hold DEPTH
//  instructions of FIELDS x WIDTH bits each. The external 32-bit port loads the shadow bank while
//  the controller fetches from the active bank. A swap handshake exchanges the two banks.
//  Fetch has registered 1-cycle latency. Out-of-range accesses are flagged, not aliased.
// PARAMETERS
//  FIELDS  32  sub-words per instruction
//  WIDTH   32  bits per sub-word (must be <= EXT_W; data is truncated to the low WIDTH bits)
//  DEPTH   2   instructions per bank
//  EXT_W   32  external address/data width
//  PC_W    32  program-counter width
// PORTS
//  clk               in   1              clock, rising edge
//  reset             in   1              synchronous, active-low
//  wr_en_ext_im      in   1              external write strobe
//  wr_addr_ext_im    in   EXT_W          {word, field}; field = low FB=clog2(FIELDS) bits, word = next DB=clog2(DEPTH) bits
//  wr_data_ext_im    in   EXT_W          write data
//  wr_ready_ext_im   out  1              high when a write is accepted this cycle
//  wr_err            out  1              sticky: an out-of-range write was dropped
//  swap_req          in   1              request active/shadow exchange (level, held until swap_ack)
//  swap_ack          out  1              1-cycle pulse when the exchange takes effect
//  active_bank       out  1              bank currently fetched from
//  pc_valid          in   1              fetch strobe
//  PC                in   PC_W           instruction index
//  instruction       out  FIELDS*WIDTH   fetched instruction
//  instruction_valid out  1              fetch result valid
//  pc_err            out  1              1-cycle pulse alongside instruction_valid when PC >= DEPTH
// BEHAVIOUR
//  Reset (reset=0 at posedge):
//   - both banks zeroed; active_bank=0; FSM=IDLE.
//   - All outputs 0, except wr_ready_ext_im=1 once reset is released.
//  Write:
//   - Accepted when wr_en_ext_im && wr_ready_ext_im.
//   - Targets the shadow bank (~active_bank), field slice [field*WIDTH +: WIDTH] of the word.
//   - Address bits above FB+DB nonzero, or word >= DEPTH -> write dropped, wr_err set until reset.
//   - field >= FIELDS (non-power-of-2 FIELDS) -> write dropped, wr_err set until reset.
//  Fetch:
//   - pc_valid at cycle N -> at N+1: instruction = active[PC], instruction_valid=1.
//   - PC >= DEPTH -> instruction=0, pc_err=1.
//   - Without pc_valid: instruction_valid=0; instruction holds its last value.
//   - Fetch never reads the shadow bank; writes never disturb fetched data.
//  Swap FSM:
//   - IDLE: swap_req=1 -> PEND. wr_ready_ext_im drops to 0 from the next cycle.
//     A write accepted in the same cycle as swap_req completes into the old shadow bank.
//   - PEND: toggle active_bank at the end of this cycle -> ACK.
//   - ACK: swap_ack=1, wr_ready_ext_im=1 -> IDLE. Requester must drop swap_req on swap_ack.
//     If swap_req is still high in IDLE, a new swap begins.
//   - Fetch at the swap edge: pc_valid in PEND reads the old bank; pc_valid in ACK reads the new bank.
//   - Reset in any state -> IDLE, active_bank=0, pending swap discarded.
//  No combinational path from inputs to outputs except wr_ready_ext_im (FSM-registered only).
// STRUCTURE
//  Package im_pkg:
//   - localparams FB, DB derived via $clog2.
//   - typedef im_state_t {IDLE, PEND, ACK}.
//   - typedef for the instruction word.
//  Sub-module im_bank: one bank, one sub-word write port, one full-word registered-free read
//  (combinational array read). Instantiated twice; top holds FSM, decode, muxing and output regs.
// TESTING
//  1 Reset -> all 64 sub-words of both banks read 0; active_bank=0; wr_ready_ext_im=1.
//  2 Write addr 0x21 data 0xDEADBEEF, swap, pc_valid PC=1 -> next cycle field1 of instruction
//    = 0xDEADBEEF, instruction_valid=1.
//  3 Write addr 0x40 (word 2, DEPTH=2) -> wr_err=1, no bank changes; PC=5 fetch -> instruction=0, pc_err=1.
//  4 Fetch PC=0 every cycle while swap_req is raised -> data switches banks exactly at the ACK-cycle
//    fetch; swap_ack is a single pulse.
//  5 wr_en_ext_im and swap_req in the same cycle -> write lands in the pre-swap shadow bank, now active.
//  6 reset asserted during PEND -> active_bank=0, no swap_ack, memory cleared.

Source files
------------

// File: rtl/im_pkg.sv
// Shared definitions for the double-buffered instruction memory.
// The defaults here describe the standard 32 x 32-bit, two-instruction configuration;
// modules derive their own widths from their parameters so other sizes also elaborate.
// FIELDS and DEPTH are expected to be at least 2, so that the field and word address
// slices have a nonzero width.
package im_pkg;

    localparam int FIELDS_DEF = 32;
    localparam int WIDTH_DEF  = 32;
    localparam int DEPTH_DEF  = 2;
    localparam int EXT_W_DEF  = 32;
    localparam int PC_W_DEF   = 32;

    // Address split of the external write port: {upper (must be 0), word, field}.
    localparam int FB = $clog2(FIELDS_DEF);
    localparam int DB = $clog2(DEPTH_DEF);

    typedef enum logic [1:0] {
        IDLE,
        PEND,
        ACK
    } im_state_t;

    typedef logic [FIELDS_DEF*WIDTH_DEF-1:0] im_word_t;

endpackage

// File: rtl/im_bank.sv
// One instruction bank: DEPTH words of FIELDS x WIDTH bits.
// Writes update a single sub-word; the read port returns a whole word combinationally.
// The caller guarantees indices are in range before enabling a write.
module im_bank
    import im_pkg::*;
#(
    parameter int FIELDS = FIELDS_DEF,
    parameter int WIDTH  = WIDTH_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        wr_en,
    input  logic [$clog2(DEPTH)-1:0]    wr_word,
    input  logic [$clog2(FIELDS)-1:0]   wr_field,
    input  logic [WIDTH-1:0]            wr_data,
    input  logic [$clog2(DEPTH)-1:0]    rd_word,
    output logic [FIELDS*WIDTH-1:0]     rd_data
);

    logic [FIELDS*WIDTH-1:0] mem [DEPTH];

    // Clear every word on reset; otherwise patch one sub-word when enabled.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_word][wr_field*WIDTH +: WIDTH] <= wr_data;
        end
    end

    assign rd_data = mem[rd_word];

endmodule

// File: rtl/instruction_memory_banked.sv
// Double-buffered instruction store. The external port fills the shadow bank while
// fetches are served from the active bank; a swap handshake exchanges the two.
// Holds the swap FSM, address decode, bank muxing and the registered fetch outputs.
module instruction_memory_banked
    import im_pkg::*;
#(
    parameter int FIELDS = FIELDS_DEF,
    parameter int WIDTH  = WIDTH_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int EXT_W  = EXT_W_DEF,
    parameter int PC_W   = PC_W_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en_ext_im,
    input  logic [EXT_W-1:0]         wr_addr_ext_im,
    input  logic [EXT_W-1:0]         wr_data_ext_im,
    output logic                     wr_ready_ext_im,
    output logic                     wr_err,
    input  logic                     swap_req,
    output logic                     swap_ack,
    output logic                     active_bank,
    input  logic                     pc_valid,
    input  logic [PC_W-1:0]          PC,
    output logic [FIELDS*WIDTH-1:0]  instruction,
    output logic                     instruction_valid,
    output logic                     pc_err
);

    localparam int FLD_B = $clog2(FIELDS);
    localparam int WRD_B = $clog2(DEPTH);
    localparam int DEC_B = FLD_B + WRD_B;
    localparam int IW    = FIELDS * WIDTH;

    im_state_t         state_q;
    im_state_t         state_d;
    logic              active_q;
    logic              wr_err_q;
    logic [IW-1:0]     instr_q;
    logic              instr_valid_q;
    logic              pc_err_q;

    logic [FLD_B-1:0]  wr_field;
    logic [WRD_B-1:0]  wr_word;
    logic [EXT_W-1:0]  wr_upper;
    logic [31:0]       field_ext;
    logic [31:0]       word_ext;
    logic              wr_in_range;
    logic              wr_accept;
    logic              wr_fire;

    logic [WRD_B-1:0]  rd_word;
    logic [IW-1:0]     rd_data0;
    logic [IW-1:0]     rd_data1;
    logic              pc_in_range;

    // Only the low WIDTH bits of write data are stored; the rest is intentionally ignored.
    if (EXT_W > WIDTH) begin : g_data_trunc
        logic unused_data_hi;
        assign unused_data_hi = ^wr_data_ext_im[EXT_W-1:WIDTH];
    end

    // Split the write address and reject anything that would otherwise alias.
    assign wr_field    = wr_addr_ext_im[FLD_B-1:0];
    assign wr_word     = wr_addr_ext_im[DEC_B-1:FLD_B];
    assign wr_upper    = wr_addr_ext_im >> DEC_B;
    assign field_ext   = 32'(wr_field);
    assign word_ext    = 32'(wr_word);
    assign wr_in_range = (wr_upper == '0) && (field_ext < 32'(FIELDS)) && (word_ext < 32'(DEPTH));

    // Writes are stalled only while the exchange is in flight.
    assign wr_ready_ext_im = (state_q != PEND);
    assign wr_accept       = wr_en_ext_im && wr_ready_ext_im;
    assign wr_fire         = wr_accept && wr_in_range;

    assign rd_word     = PC[WRD_B-1:0];
    assign pc_in_range = (PC < PC_W'(DEPTH));

    im_bank #(
        .FIELDS (FIELDS),
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH)
    ) u_bank0 (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_fire && active_q),
        .wr_word  (wr_word),
        .wr_field (wr_field),
        .wr_data  (wr_data_ext_im[WIDTH-1:0]),
        .rd_word  (rd_word),
        .rd_data  (rd_data0)
    );

    im_bank #(
        .FIELDS (FIELDS),
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH)
    ) u_bank1 (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_fire && !active_q),
        .wr_word  (wr_word),
        .wr_field (wr_field),
        .wr_data  (wr_data_ext_im[WIDTH-1:0]),
        .rd_word  (rd_word),
        .rd_data  (rd_data1)
    );

    // Swap FSM state register; reset discards any exchange in progress.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Swap FSM next-state: request -> one cycle pending -> one cycle acknowledge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (swap_req) state_d = PEND;
            PEND:    state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The banks exchange roles on the edge that leaves PEND.
    always_ff @(posedge clk) begin
        if (!reset) begin
            active_q <= 1'b0;
        end else if (state_q == PEND) begin
            active_q <= ~active_q;
        end
    end

    // Sticky flag for any accepted write that had to be dropped.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_err_q <= 1'b0;
        end else if (wr_accept && !wr_in_range) begin
            wr_err_q <= 1'b1;
        end
    end

    // Registered fetch from the active bank; out-of-range PCs return zero and flag pc_err.
    always_ff @(posedge clk) begin
        if (!reset) begin
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            pc_err_q      <= 1'b0;
        end else if (pc_valid) begin
            instr_valid_q <= 1'b1;
            if (pc_in_range) begin
                instr_q  <= active_q ? rd_data1 : rd_data0;
                pc_err_q <= 1'b0;
            end else begin
                instr_q  <= '0;
                pc_err_q <= 1'b1;
            end
        end else begin
            instr_valid_q <= 1'b0;
            pc_err_q      <= 1'b0;
        end
    end

    assign swap_ack          = (state_q == ACK);
    assign active_bank       = active_q;
    assign wr_err            = wr_err_q;
    assign instruction       = instr_q;
    assign instruction_valid = instr_valid_q;
    assign pc_err            = pc_err_q;

endmodule

// File: tb/tb_instruction_memory_banked.sv
// Directed bench for instruction_memory_banked in its default 32 x 32-bit, depth-2 form.
module tb_instruction_memory_banked;

    logic          clk;
    logic          reset;
    logic          wr_en_ext_im;
    logic [31:0]   wr_addr_ext_im;
    logic [31:0]   wr_data_ext_im;
    logic          wr_ready_ext_im;
    logic          wr_err;
    logic          swap_req;
    logic          swap_ack;
    logic          active_bank;
    logic          pc_valid;
    logic [31:0]   PC;
    logic [1023:0] instruction;
    logic          instruction_valid;
    logic          pc_err;

    int checks;
    int errors;

    logic [1023:0] exp_word;

    instruction_memory_banked dut (
        .clk               (clk),
        .reset             (reset),
        .wr_en_ext_im      (wr_en_ext_im),
        .wr_addr_ext_im    (wr_addr_ext_im),
        .wr_data_ext_im    (wr_data_ext_im),
        .wr_ready_ext_im   (wr_ready_ext_im),
        .wr_err            (wr_err),
        .swap_req          (swap_req),
        .swap_ack          (swap_ack),
        .active_bank       (active_bank),
        .pc_valid          (pc_valid),
        .PC                (PC),
        .instruction       (instruction),
        .instruction_valid (instruction_valid),
        .pc_err            (pc_err)
    );

    // 100 MHz free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive every DUT input for the coming cycle.
    task automatic applyStimulus(input logic wen, input logic [31:0] addr, input logic [31:0] data,
                                 input logic sreq, input logic pv, input logic [31:0] pc);
        wr_en_ext_im   = wen;
        wr_addr_ext_im = addr;
        wr_data_ext_im = data;
        swap_req       = sreq;
        pc_valid       = pv;
        PC             = pc;
    endtask

    // Narrow comparison.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Whole-instruction comparison, reporting the first differing sub-word.
    task automatic checkWide(input string tag, input logic [1023:0] observed, input logic [1023:0] expected);
        int bad;
        bad = 0;
        for (int i = 31; i >= 0; i--) begin
            if (observed[i*32 +: 32] !== expected[i*32 +: 32]) bad = i;
        end
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s field %0d observed=%h expected=%h", tag, bad,
                   observed[bad*32 +: 32], expected[bad*32 +: 32]);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);

        // Reset state.
        tick();
        tick();
        checkOutput("rst_active", {31'b0, active_bank}, 32'd0);
        checkOutput("rst_ivalid", {31'b0, instruction_valid}, 32'd0);
        checkOutput("rst_ack", {31'b0, swap_ack}, 32'd0);
        checkOutput("rst_wrerr", {31'b0, wr_err}, 32'd0);
        checkOutput("rst_pcerr", {31'b0, pc_err}, 32'd0);
        checkWide("rst_instr", instruction, '0);
        reset = 1'b1;
        tick();
        checkOutput("rst_ready", {31'b0, wr_ready_ext_im}, 32'd1);

        // Bank 0 is empty after reset.
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'd0);
        tick();
        checkWide("b0_w0_zero", instruction, '0);
        checkOutput("b0_w0_valid", {31'b0, instruction_valid}, 32'd1);
        checkOutput("b0_w0_pcerr", {31'b0, pc_err}, 32'd0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'd1);
        tick();
        checkWide("b0_w1_zero", instruction, '0);

        // Write word 1 field 1 of the shadow bank, then swap.
        applyStimulus(1'b1, 32'h21, 32'hDEADBEEF, 1'b0, 1'b0, 32'd0);
        tick();
        checkOutput("w21_noerr", {31'b0, wr_err}, 32'd0);
        checkOutput("idle_ivalid", {31'b0, instruction_valid}, 32'd0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'd0);
        tick();
        checkOutput("pend_ready", {31'b0, wr_ready_ext_im}, 32'd0);
        checkOutput("pend_ack", {31'b0, swap_ack}, 32'd0);
        tick();
        checkOutput("ack_pulse", {31'b0, swap_ack}, 32'd1);
        checkOutput("ack_active", {31'b0, active_bank}, 32'd1);
        checkOutput("ack_ready", {31'b0, wr_ready_ext_im}, 32'd1);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
        tick();
        checkOutput("ack_drop", {31'b0, swap_ack}, 32'd0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'd0);
        tick();
        checkWide("b1_w0_zero", instruction, '0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'd1);
        tick();
        exp_word = '0;
        exp_word[63:32] = 32'hDEADBEEF;
        checkWide("b1_w1_beef", instruction, exp_word);
        checkOutput("b1_w1_valid", {31'b0, instruction_valid}, 32'd1);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
        tick();
        checkOutput("hold_ivalid", {31'b0, instruction_valid}, 32'd0);
        checkWide("hold_instr", instruction, exp_word);

        // Out-of-range write and fetch.
        applyStimulus(1'b1, 32'h40, 32'h12345678, 1'b0, 1'b0, 32'd0);
        tick();
        checkOutput("w40_err", {31'b0, wr_err}, 32'd1);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'd5);
        tick();
        checkWide("pc5_instr", instruction, '0);
        checkOutput("pc5_pcerr", {31'b0, pc_err}, 32'd1);
        checkOutput("pc5_valid", {31'b0, instruction_valid}, 32'd1);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'd1);
        tick();
        checkOutput("pcerr_pulse", {31'b0, pc_err}, 32'd0);
        checkWide("b1_w1_intact", instruction, exp_word);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
        tick();
        checkOutput("wrerr_sticky", {31'b0, wr_err}, 32'd1);

        // Load bank 0 word 0, then swap while fetching PC 0 every cycle.
        applyStimulus(1'b1, 32'h00, 32'hA5A5A5A5, 1'b0, 1'b0, 32'd0);
        tick();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'd0);
        tick();
        checkWide("sw_idle_old", instruction, '0);
        checkOutput("sw_idle_ack", {31'b0, swap_ack}, 32'd0);
        tick();
        checkWide("sw_pend_old", instruction, '0);
        checkOutput("sw_ack_pulse", {31'b0, swap_ack}, 32'd1);
        checkOutput("sw_ack_active", {31'b0, active_bank}, 32'd0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'd0);
        tick();
        exp_word = '0;
        exp_word[31:0] = 32'hA5A5A5A5;
        checkWide("sw_ack_new", instruction, exp_word);
        checkOutput("sw_ack_single", {31'b0, swap_ack}, 32'd0);
        tick();
        checkWide("sw_after_new", instruction, exp_word);
        checkOutput("sw_ack_stays", {31'b0, swap_ack}, 32'd0);

        // Write and swap request in the same cycle: the write lands in the bank that becomes active.
        applyStimulus(1'b1, 32'h22, 32'hCAFEF00D, 1'b1, 1'b0, 32'd0);
        tick();
        checkOutput("ws_pend_ready", {31'b0, wr_ready_ext_im}, 32'd0);
        applyStimulus(1'b1, 32'h23, 32'h0BADF00D, 1'b1, 1'b0, 32'd0);
        tick();
        checkOutput("ws_ack", {31'b0, swap_ack}, 32'd1);
        checkOutput("ws_active", {31'b0, active_bank}, 32'd1);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'd1);
        tick();
        tick();
        exp_word = '0;
        exp_word[63:32] = 32'hDEADBEEF;
        exp_word[95:64] = 32'hCAFEF00D;
        checkWide("ws_landed", instruction, exp_word);

        // Reset during PEND discards the swap and clears everything.
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'd0);
        tick();
        checkOutput("rp_pend", {31'b0, wr_ready_ext_im}, 32'd0);
        reset = 1'b0;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
        tick();
        checkOutput("rp_active", {31'b0, active_bank}, 32'd0);
        checkOutput("rp_ack", {31'b0, swap_ack}, 32'd0);
        checkOutput("rp_wrerr", {31'b0, wr_err}, 32'd0);
        reset = 1'b1;
        tick();
        checkOutput("rp_ack_after", {31'b0, swap_ack}, 32'd0);
        checkOutput("rp_active_after", {31'b0, active_bank}, 32'd0);
        checkOutput("rp_ready", {31'b0, wr_ready_ext_im}, 32'd1);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'd0);
        tick();
        checkWide("rp_b0_w0", instruction, '0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'd0);
        tick();
        tick();
        checkOutput("rp_swap_ack", {31'b0, swap_ack}, 32'd1);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'd1);
        tick();
        checkWide("rp_b1_w1", instruction, '0);
        checkOutput("rp_b1_active", {31'b0, active_bank}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
